// File: rtl/fifo_thd_send.sv
// Threshold-triggered send FIFO: buffers words and bursts them out between a high and low watermark.
// Optional macro FIFO_THD_OVF_CNT_EN adds a saturating 16-bit dropped-write counter on port ovf_cnt.
module fifo_thd_send #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW:0]   cfg_thd_lo,
  input  logic [AW:0]   cfg_thd_hi,
  input  logic          cfg_flush,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic [AW:0]   usedw,
  output logic          ovf
`ifdef FIFO_THD_OVF_CNT_EN
  ,
  output logic [15:0]   ovf_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [AW:0]   DEPTH     = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   USEDW_ONE = (AW+1)'(1'b1);
  localparam logic [AW:0]   USEDW_0   = (AW+1)'(1'b0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     usedw_r;
  logic [DW-1:0]   dout_r;
  logic            dout_vld_r;
  logic            ovf_r;
  logic [DW-1:0]   mem_r [2**AW];
  logic            wr_s;
  logic            drop_s;
  logic            enter_s;
  logic            leave_s;
  logic            send_ok_s;
  logic            pop_s;

  assign din_rdy  = (usedw_r != DEPTH);
  assign wr_s     = din_vld & din_rdy;
  assign drop_s   = din_vld & ~din_rdy;
  assign enter_s  = (usedw_r > cfg_thd_hi) || (cfg_flush && (usedw_r != USEDW_0));
  assign leave_s  = ((usedw_r < cfg_thd_lo) && !cfg_flush) || (usedw_r == USEDW_0);
  assign pop_s    = send_ok_s && (usedw_r != USEDW_0) && (!dout_vld_r || dout_rdy);

  assign usedw    = usedw_r;
  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign ovf      = ovf_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decision from the registered fill level
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (enter_s) state_nxt_s = SEND; else state_nxt_s = IDLE;
      SEND:    if (leave_s) state_nxt_s = IDLE; else state_nxt_s = SEND;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output: the cycle that decides to leave SEND does not pop, so the
  // release threshold leaves exactly the words below it behind
  always_comb begin
    send_ok_s = 1'b0;
    case (state_r)
      IDLE:    send_ok_s = 1'b0;
      SEND:    if (leave_s) send_ok_s = 1'b0; else send_ok_s = 1'b1;
      default: send_ok_s = 1'b0;
    endcase
  end

  // Storage array; contents are never reset and are only reachable through valid pointers
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      usedw_r  <= USEDW_0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_s, pop_s})
        2'b10:   usedw_r <= usedw_r + USEDW_ONE;
        2'b01:   usedw_r <= usedw_r - USEDW_ONE;
        default: usedw_r <= usedw_r;
      endcase
    end
  end

  // Output register: holds the word until downstream takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r     <= {DW{1'b0}};
      dout_vld_r <= 1'b0;
    end else if (pop_s) begin
      dout_r     <= mem_r[rd_ptr_r];
      dout_vld_r <= 1'b1;
    end else if (dout_rdy) begin
      dout_vld_r <= 1'b0;
    end else begin
      dout_vld_r <= dout_vld_r;
    end
  end

  // Sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

`ifdef FIFO_THD_OVF_CNT_EN
  logic [15:0] ovf_cnt_r;
  assign ovf_cnt = ovf_cnt_r;

  // Saturating count of dropped writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= 16'h0000;
    end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'h0001;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_thd_send.sv
// Self-checking bench for fifo_thd_send (DW=8, AW=4): queue-based model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_thd_send;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   cfg_thd_lo = 5'd2;
  logic [AW:0]   cfg_thd_hi = 5'd5;
  logic          cfg_flush = 1'b0;
  logic [DW-1:0] din = 8'h00;
  logic          din_vld = 1'b0;
  logic          din_rdy;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy = 1'b1;
  logic [AW:0]   usedw;
  logic          ovf;
  logic [15:0]   ovf_cnt;

  int vectors = 0;
  int miscompares = 0;

  fifo_thd_send #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_thd_lo(cfg_thd_lo), .cfg_thd_hi(cfg_thd_hi), .cfg_flush(cfg_flush),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .usedw(usedw), .ovf(ovf)
`ifdef FIFO_THD_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

`ifndef FIFO_THD_OVF_CNT_EN
  assign ovf_cnt = 16'h0000;
`endif

  initial forever #5 clk = ~clk;

  // Behavioural model: stored words, sending flag, output slot, and the stream of accepted outputs
  logic [7:0] mq[$];
  logic [7:0] got[$];
  bit         m_send = 1'b0;
  bit         m_vld = 1'b0;
  logic [7:0] m_dout = 8'h00;
  bit         m_ovf = 1'b0;
  int         m_ovf_cnt = 0;
  int         m_cnt;
  bit         m_go;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_send = 1'b0; m_vld = 1'b0; m_dout = 8'h00; m_ovf = 1'b0; m_ovf_cnt = 0;
      end else begin
        m_cnt = mq.size();
        // a sending FIFO keeps draining until it is empty or has fallen below the release level
        m_go = m_send && !(m_cnt == 0 || (m_cnt < int'(cfg_thd_lo) && !cfg_flush));
        if (m_vld && dout_rdy) got.push_back(m_dout);
        if (m_go && (!m_vld || dout_rdy)) begin
          m_dout = mq.pop_front();
          m_vld = 1'b1;
        end else if (dout_rdy) begin
          m_vld = 1'b0;
        end
        if (din_vld) begin
          if (m_cnt < DEPTH) mq.push_back(din);
          else begin
            m_ovf = 1'b1;
            if (m_ovf_cnt < 65535) m_ovf_cnt++;
          end
        end
        if (m_send) m_send = m_go;
        else m_send = (m_cnt > int'(cfg_thd_hi)) || (cfg_flush && m_cnt != 0);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("usedw", int'(usedw), mq.size());
      chk("din_rdy", int'(din_rdy), int'(mq.size() != DEPTH));
      chk("dout_vld", int'(dout_vld), int'(m_vld));
      chk("dout", int'(dout), int'(m_dout));
      chk("ovf", int'(ovf), int'(m_ovf));
`ifdef FIFO_THD_OVF_CNT_EN
      chk("ovf_cnt", int'(ovf_cnt), m_ovf_cnt);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] d);
    din = d; din_vld = 1'b1;
    step();
    din_vld = 1'b0;
  endtask

  task automatic drain();
    cfg_flush = 1'b1;
    idle(24);
    cfg_flush = 1'b0;
    step();
  endtask

  task automatic chk_seq(input string name, input int base, input int first, input int n);
    chk({name, "_count"}, got.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < got.size()) chk(name, int'(got[base + i]), first + i);
    end
  endtask

  int base;
  int k;

  initial begin
    idle(3);
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_din_rdy", int'(din_rdy), 1);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    step();

    // Threshold burst: hi=5, lo=2, six writes
    base = got.size();
    for (int i = 1; i <= 6; i++) begin
      wr(8'(i));
      chk("early_vld", int'(dout_vld), 0);
    end
    idle(15);
    chk("thd_leftover", int'(usedw), 1);
    chk_seq("thd_order", base, 8'h01, 5);
    drain();
    chk_seq("thd_tail", base + 5, 8'h06, 1);
    chk("thd_empty", int'(usedw), 0);

    // Flush below threshold
    cfg_thd_hi = 5'd10;
    base = got.size();
    wr(8'h31); wr(8'h32); wr(8'h33);
    idle(5);
    chk("flush_hold", int'(usedw), 3);
    chk("flush_none_out", got.size() - base, 0);
    cfg_flush = 1'b1;
    idle(8);
    chk_seq("flush_order", base, 8'h31, 3);
    chk("flush_empty", int'(usedw), 0);
    cfg_flush = 1'b0;
    step();

    // Backpressure stall for three cycles
    cfg_thd_hi = 5'd5;
    base = got.size();
    for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i));
    k = 0;
    while (!dout_vld && k < 20) begin step(); k++; end
    chk("stall_vld_seen", int'(dout_vld), 1);
    chk("stall_first", int'(dout), 8'h40);
    dout_rdy = 1'b0;
    step();
    base = got.size() - base;
    for (int i = 0; i < 3; i++) begin
      chk("stall_dout", int'(dout), 8'h40);
      chk("stall_usedw", int'(usedw), 7);
      if (i < 2) step();
    end
    base = got.size() - base;
    dout_rdy = 1'b1;
    idle(15);
    chk_seq("stall_order", base, 8'h40, 7);
    chk("stall_leftover", int'(usedw), 1);
    drain();
    chk_seq("stall_tail", base + 7, 8'h47, 1);

    // Overflow: fill 16, drop the 17th
    cfg_thd_hi = 5'd16;
    cfg_thd_lo = 5'd0;
    base = got.size();
    for (int i = 0; i < 16; i++) wr(8'h50 + 8'(i));
    chk("full_din_rdy", int'(din_rdy), 0);
    chk("full_usedw", int'(usedw), 16);
    chk("full_no_ovf", int'(ovf), 0);
    wr(8'hEE);
    chk("ovf_usedw", int'(usedw), 16);
    chk("ovf_flag", int'(ovf), 1);
`ifdef FIFO_THD_OVF_CNT_EN
    chk("ovf_cnt_lit", int'(ovf_cnt), 1);
`endif
    drain();
    chk_seq("ovf_order", base, 8'h50, 16);
    chk("ovf_sticky", int'(ovf), 1);

    // Concurrent write and pop at usedw=8
    cfg_thd_hi = 5'd6;
    cfg_thd_lo = 5'd2;
    base = got.size();
    for (int i = 0; i < 8; i++) wr(8'h60 + 8'(i));
    chk("conc_start", int'(usedw), 8);
    for (int i = 8; i < 28; i++) begin
      wr(8'h60 + 8'(i));
      chk("conc_usedw", int'(usedw), 8);
    end
    idle(20);
    chk("conc_leftover", int'(usedw), 1);
    drain();
    chk_seq("conc_order", base, 8'h60, 28);

    // Asynchronous reset mid-burst with a word waiting on dout
    cfg_thd_hi = 5'd3;
    cfg_thd_lo = 5'd1;
    dout_rdy = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'h80 + 8'(i));
    idle(3);
    chk("pre_rst_vld", int'(dout_vld), 1);
    chk("pre_rst_ovf", int'(ovf), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_vld", int'(dout_vld), 0);
    chk("rst_mid_usedw", int'(usedw), 0);
    chk("rst_mid_ovf", int'(ovf), 0);
    chk("rst_mid_din_rdy", int'(din_rdy), 1);
    chk("rst_mid_ovf_cnt", int'(ovf_cnt), 0);
    idle(2);
    rst_n = 1'b1;
    step();
    cfg_thd_hi = 5'd0;
    dout_rdy = 1'b1;
    base = got.size();
    wr(8'hA5);
    idle(6);
    chk_seq("post_rst", base, 8'hA5, 1);
    chk("post_rst_usedw", int'(usedw), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
